alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shares the single 16-bit combinational ALU between two requesters, port 0 and port 1.
- Arbitrates round-robin and drives the ALU operand/op bus from registers.
- Holds the operands stable for ALU_LAT cycles, captures the result, and returns it to the owning requester over a valid/ready response channel.
- One operation is outstanding at a time. The block sits directly in front of the ALU instance in the datapath.

Parameters:
- W, 16, data width of operands and result.
- ALU_LAT, 2, number of cycles the operands are held before the result is sampled (legal range 1..15).
- RSV_OP, 4'hF, reserved op code; it is rejected without using the ALU.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N = 0,1) request valid.
- reqN_ready  out  1  request accepted this cycle (combinational).
- reqN_op  in  4  ALU op code.
- reqN_a, reqN_b  in  W  operands.
- rspN_valid  out  1  response valid for requester N.
- rspN_ready  in  1  requester N accepts the response.
- rsp_data  out  W  result, shared by both response ports.
- rsp_err  out  1  set when the op was RSV_OP.
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_op  out  4  registered op to the ALU.
- alu_result  in  W  combinational ALU output.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; alu_a, alu_b, alu_op, rsp_data, rsp_err = 0.
  - rspN_valid=0; owner=0.
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE arbitration:
  - Grant goes to the single valid port.
  - If both are valid, grant goes to the port != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle.
  - A requester must hold valid, op and operands until it sees ready.
- Accept edge (valid & ready):
  - alu_a/alu_b/alu_op <= request fields; owner <= N; last_grant <= N; cnt <= ALU_LAT-1.
  - If op==RSV_OP: go directly to RESP with rsp_data=0 and rsp_err=1. The ALU registers are still loaded.
  - Otherwise go to EXEC.
- EXEC:
  - alu_* are held constant.
  - Each edge: if cnt==0, rsp_data <= alu_result, rsp_err <= 0, go to RESP; else cnt decrements.
  - The result is sampled at the ALU_LAT-th edge after acceptance.
- RESP:
  - rsp<owner>_valid=1; the other port's rsp_valid stays 0.
  - rsp_data and rsp_err are held stable.
  - On the edge with rsp<owner>_ready=1: go to IDLE; rsp_valid drops next cycle.
  - No request is accepted in EXEC or RESP.
- Minimum issue interval is ALU_LAT+2 cycles per operation, because IDLE costs 1 cycle.
- Stall: rsp_ready held low keeps the block in RESP indefinitely, and the other port's request waits.
- Arithmetic: the block does no arithmetic. alu_result passes through at width W; overflow semantics belong to the ALU.
- Reset mid-operation: all state clears immediately, the in-flight result is discarded, and no response is issued.
- rsp_data retains its last value in IDLE.

Optional Feature:
- ALU_SCHED_PERF_EN defined:
  - Adds outputs perf_done0, perf_done1 (16-bit each).
  - perf_doneN increments on each rspN handshake and wraps at 16'hFFFF -> 0.
  - Adds perf_stall (16-bit, wrapping), which increments every cycle where reqN_valid=1 and reqN_ready=0 for either port. If both ports stall in the same cycle it counts once.
  - All perf counters reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Bench ALU stub is result=a+b+op. ALU_LAT=2.
- Single op: req0 op=4'h6, a=16'h0005, b=16'h0002 -> ready0 high in the same cycle; alu_a=5 after the accept edge; rsp0_valid rises 3 edges after accept with rsp_data=16'h000D, rsp_err=0; rsp1_valid stays 0.
- Tie round-robin: both valid from reset, responses ready=1 -> grant order 0,1,0,1; each grant lasts one cycle; acceptances spaced 4 cycles apart.
- Reserved op: req1 op=4'hF, a=16'h1234 -> rsp1_valid 1 edge after accept, rsp_data=0, rsp_err=1.
- Back-pressure: rsp0_ready=0 for 10 cycles while req1 is valid -> block stays in RESP; ready1=0 throughout; rsp_data is stable; req1 is accepted the cycle after rsp0 handshakes and IDLE is re-entered.
- Reset in EXEC: rst_n low 1 cycle after accept -> all outputs return to 0 asynchronously; no rsp_valid follows; the next tie grants port 0.
- Wrap case, ALU_LAT=1: a=16'hFFFF, b=16'h0001, op=0 -> rsp_data=16'h0000 two edges after accept. With ALU_SCHED_PERF_EN defined, perf_done0 increments by 1.

Source files
------------

// File: rtl/alu_sched.sv
//==============================================================================
// Module   : alu_sched
// Purpose  : Shares one combinational ALU between two requesters. Requests are
//            arbitrated round-robin in IDLE, the accepted operands/op are
//            registered onto the ALU bus and held for ALU_LAT cycles, the
//            result is captured and returned to the owning requester over a
//            valid/ready response channel. One operation in flight at a time.
// Ports    : clk, rst_n (async, active low)
//            req0_*/req1_* : valid/ready request channels (op, a, b)
//            rsp0_*/rsp1_* : valid/ready response channels
//            rsp_data, rsp_err : shared response payload
//            alu_a, alu_b, alu_op : registered ALU inputs
//            alu_result    : combinational ALU output
//            busy          : high whenever an operation is in progress
//            perf_done0/1, perf_stall : only with ALU_SCHED_PERF_EN defined
// Options  : `define ALU_SCHED_PERF_EN adds performance counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_sched #(
    parameter int         W       = 16,
    parameter int         ALU_LAT = 2,
    parameter logic [3:0] RSV_OP  = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         busy
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [15:0]  perf_done0,
    output logic [15:0]  perf_done1,
    output logic [15:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t         state;
    state_t         state_nxt;
    logic           owner;
    logic           last_grant;
    logic [3:0]     cnt;

    logic           acc;
    logic           acc_port;
    logic [3:0]     acc_op;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;
    logic           rsp_hs;

    // Single valid port wins; on a tie the port that did not win last time
    // wins. last_grant resets to 1 so port 0 takes the first tie.
    assign req0_ready = (state == S_IDLE) && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = (state == S_IDLE) && req1_valid && (!req0_valid || !last_grant);

    assign acc      = req0_ready || req1_ready;
    assign acc_port = req1_ready;
    assign acc_op   = acc_port ? req1_op : req0_op;
    assign acc_a    = acc_port ? req1_a  : req0_a;
    assign acc_b    = acc_port ? req1_b  : req0_b;

    assign rsp0_valid = (state == S_RESP) && !owner;
    assign rsp1_valid = (state == S_RESP) &&  owner;
    assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    // Reserved op bypasses the ALU entirely.
                    state_nxt = (acc_op == RSV_OP) ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: ALU bus registers, latency counter and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'd0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
        end else begin
            if (acc) begin
                alu_a      <= acc_a;
                alu_b      <= acc_b;
                alu_op     <= acc_op;
                owner      <= acc_port;
                last_grant <= acc_port;
                cnt        <= CNT_INIT;
                if (acc_op == RSV_OP) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == S_EXEC) begin
                if (cnt == 4'd0) begin
                    rsp_data <= alu_result;
                    rsp_err  <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic stall;

    // A cycle where either port is held off counts once.
    assign stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_done0 <= 16'd0;
            perf_done1 <= 16'd0;
            perf_stall <= 16'd0;
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                perf_done0 <= perf_done0 + 16'd1;
            end
            if (rsp1_valid && rsp1_ready) begin
                perf_done1 <= perf_done1 + 16'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
//==============================================================================
// Module   : tb_alu_sched
// Purpose  : Directed self-checking bench for alu_sched. The ALU is modelled
//            as result = a + b + op. u_dut uses ALU_LAT=2, u_dut1 uses
//            ALU_LAT=1 for the wrap case.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_sched;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;

    // ALU_LAT = 2 instance
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data, alu_a, alu_b, alu_result;
    logic         rsp_err, busy;
    logic [3:0]   alu_op;

    // ALU_LAT = 1 instance
    logic         d1_req0_valid, d1_req0_ready, d1_req1_ready;
    logic [3:0]   d1_req0_op;
    logic [W-1:0] d1_req0_a, d1_req0_b;
    logic         d1_rsp0_valid, d1_rsp0_ready, d1_rsp1_valid;
    logic [W-1:0] d1_rsp_data, d1_alu_a, d1_alu_b, d1_alu_result;
    logic         d1_rsp_err, d1_busy;
    logic [3:0]   d1_alu_op;

`ifdef ALU_SCHED_PERF_EN
    logic [15:0]  perf_done0, perf_done1, perf_stall;
    logic [15:0]  d1_perf_done0, d1_perf_done1, d1_perf_stall;
`endif

    int n_checks;
    int n_fail;

    assign alu_result    = alu_a + alu_b + {12'd0, alu_op};
    assign d1_alu_result = d1_alu_a + d1_alu_b + {12'd0, d1_alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_sched #(.W(W), .ALU_LAT(2), .RSV_OP(4'hF)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
`ifdef ALU_SCHED_PERF_EN
        ,
        .perf_done0 (perf_done0),
        .perf_done1 (perf_done1),
        .perf_stall (perf_stall)
`endif
    );

    alu_sched #(.W(W), .ALU_LAT(1), .RSV_OP(4'hF)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (d1_req0_valid),
        .req0_ready (d1_req0_ready),
        .req0_op    (d1_req0_op),
        .req0_a     (d1_req0_a),
        .req0_b     (d1_req0_b),
        .req1_valid (1'b0),
        .req1_ready (d1_req1_ready),
        .req1_op    (4'd0),
        .req1_a     (16'd0),
        .req1_b     (16'd0),
        .rsp0_valid (d1_rsp0_valid),
        .rsp0_ready (d1_rsp0_ready),
        .rsp1_valid (d1_rsp1_valid),
        .rsp1_ready (1'b1),
        .rsp_data   (d1_rsp_data),
        .rsp_err    (d1_rsp_err),
        .alu_a      (d1_alu_a),
        .alu_b      (d1_alu_b),
        .alu_op     (d1_alu_op),
        .alu_result (d1_alu_result),
        .busy       (d1_busy)
`ifdef ALU_SCHED_PERF_EN
        ,
        .perf_done0 (d1_perf_done0),
        .perf_done1 (d1_perf_done1),
        .perf_stall (d1_perf_stall)
`endif
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== 4'd0) begin n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%h expected 0", alu_a, alu_b, alu_op); end
        n_checks++; if (rsp_data !== 16'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data=%h err=%b expected 0", rsp_data, rsp_err); end
        n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_op = 4'h6; req0_a = 16'h0005; req0_b = 16'h0002;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b expected 1", req0_ready); end
        @(negedge clk);   // accept edge passed
        req0_valid = 1'b0;
        n_checks++; if (alu_a !== 16'h0005 || alu_op !== 4'h6) begin n_fail++; $display("FAIL single_alu_regs: got a=%h op=%h expected a=0005 op=6", alu_a, alu_op); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", rsp0_valid); end
        @(negedge clk);   // third edge after accept
        n_checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_valid: got %b%b expected 10", rsp0_valid, rsp1_valid); end
        n_checks++; if (rsp_data !== 16'h000D || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_data: got %h err=%b expected 000d err=0", rsp_data, rsp_err); end
        @(negedge clk);   // handshake edge passed
        n_checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, rsp0_valid); end
        n_checks++; if (rsp_data !== 16'h000D) begin n_fail++; $display("FAIL single_data_retain: got %h expected 000d", rsp_data); end
    endtask

    task automatic test_round_robin();
        int gport[4];
        int gtime[4];
        int ng;
        ng = 0;
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h1; req0_a = 16'h0100; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = 4'h2; req1_a = 16'h0200; req1_b = 16'h0002;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            #1;
            n_checks++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin n_fail++; $display("FAIL rr_both_ready: cycle %0d got 11 expected at most one", i); end
            if ((req0_ready === 1'b1 || req1_ready === 1'b1) && ng < 4) begin
                gport[ng] = (req1_ready === 1'b1) ? 1 : 0;
                gtime[ng] = i;
                ng++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_SCHED_PERF_EN
        n_checks++; if (perf_stall !== 16'd13) begin n_fail++; $display("FAIL rr_perf_stall: got %0d expected 13", perf_stall); end
`endif
        n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", ng); end
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                n_checks++; if (gport[k] !== (k % 2)) begin n_fail++; $display("FAIL rr_grant_port[%0d]: got %0d expected %0d", k, gport[k], k % 2); end
                n_checks++; if (gtime[k] !== 4 * k) begin n_fail++; $display("FAIL rr_grant_time[%0d]: got %0d expected %0d", k, gtime[k], 4 * k); end
            end
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reserved();
        @(negedge clk);
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'hF; req1_a = 16'h1234; req1_b = 16'h0000;
        #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_ready1: got %b expected 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        n_checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_rsp_valid: got %b%b expected 01", rsp1_valid, rsp0_valid); end
        n_checks++; if (rsp_data !== 16'h0000 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL rsv_rsp: got data=%h err=%b expected 0000 1", rsp_data, rsp_err); end
        n_checks++; if (alu_a !== 16'h1234 || alu_op !== 4'hF) begin n_fail++; $display("FAIL rsv_alu_regs: got a=%h op=%h expected 1234 f", alu_a, alu_op); end
        rsp1_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_idle: got busy=%b valid=%b expected 0 0", busy, rsp1_valid); end
    endtask

    task automatic test_back_pressure();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h1; req0_a = 16'h0010; req0_b = 16'h0020;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b expected 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'h2; req1_a = 16'h0003; req1_b = 16'h0004;
        #1;
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_exec_ready1: got %b expected 0", req1_ready); end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0 || rsp_data !== 16'h0031) begin
                n_fail++; $display("FAIL bp_stall[%0d]: got valid0=%b ready1=%b data=%h expected 1 0 0031", i, rsp0_valid, req1_ready, rsp_data);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready1=%b valid0=%b expected 1 0", req1_ready, rsp0_valid); end
        @(negedge clk);
        req1_valid = 1'b0;
        n_checks++; if (alu_a !== 16'h0003 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_req1_accept: got a=%h busy=%b expected 0003 1", alu_a, busy); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp1_valid !== 1'b1 || rsp_data !== 16'h0009) begin n_fail++; $display("FAIL bp_rsp1: got valid=%b data=%h expected 1 0009", rsp1_valid, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'h7; req0_a = 16'h0101; req0_b = 16'h0202;
        @(negedge clk);   // accepted, port 0 now last_grant
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== 4'd0) begin n_fail++; $display("FAIL rexec_alu: got a=%h b=%h op=%h expected 0", alu_a, alu_b, alu_op); end
        n_checks++; if (rsp_data !== 16'd0 || rsp_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rexec_rsp: got data=%h err=%b busy=%b expected 0", rsp_data, rsp_err, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_no_rsp[%0d]: got %b%b expected 00", i, rsp0_valid, rsp1_valid); end
            @(negedge clk);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rexec_tie: got %b%b expected 10", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [15:0] done_before;
        done_before = 16'd0;
`ifdef ALU_SCHED_PERF_EN
        done_before = d1_perf_done0;
`endif
        d1_rsp0_ready = 1'b1;
        d1_req0_valid = 1'b1; d1_req0_op = 4'h0; d1_req0_a = 16'hFFFF; d1_req0_b = 16'h0001;
        #1;
        n_checks++; if (d1_req0_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %b expected 1", d1_req0_ready); end
        @(negedge clk);
        d1_req0_valid = 1'b0;
        n_checks++; if (d1_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early_valid: got %b expected 0", d1_rsp0_valid); end
        @(negedge clk);
        n_checks++; if (d1_rsp0_valid !== 1'b1 || d1_rsp_data !== 16'h0000 || d1_rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_rsp: got valid=%b data=%h err=%b expected 1 0000 0", d1_rsp0_valid, d1_rsp_data, d1_rsp_err);
        end
        @(negedge clk);
        n_checks++; if (d1_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %b expected 0", d1_busy); end
`ifdef ALU_SCHED_PERF_EN
        n_checks++; if (d1_perf_done0 !== done_before + 16'd1) begin n_fail++; $display("FAIL wrap_perf_done0: got %0d expected %0d", d1_perf_done0, done_before + 16'd1); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        d1_req0_valid = 1'b0; d1_req0_op = 4'd0; d1_req0_a = '0; d1_req0_b = '0;
        d1_rsp0_ready = 1'b1;

        test_reset();
        test_single();
        test_round_robin();
        test_reserved();
        @(negedge clk);
        test_back_pressure();
        test_reset_exec();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
